bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
// Groups the start/busy/done handshake, the binary operand and the BCD
// result that pass between a requester and the bin2bcd_seq converter.
//   start : conversion request (requester -> converter)
//   bin   : binary operand, WIDTH bits (requester -> converter)
//   busy  : conversion in progress (converter -> requester)
//   done  : one-cycle pulse when bcd/ovf are newly valid
//   bcd   : packed BCD result, 4*DIGITS bits, units digit in [3:0]
//   ovf   : operand did not fit in DIGITS decimal digits
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (output start, output bin, input busy, input done, input bcd, input ovf);
    modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (iterative shift-add-3). One bit of the
// operand is consumed per clock, so a conversion takes WIDTH cycles in SHIFT
// plus one DONE cycle.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : bin2bcd_seq_if slave (start, bin in; busy, done, bcd, ovf out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; bcd/ovf hold the last result
// SHIFT  | one add-3/shift iteration per clock, WIDTH iterations
// DONE   | done pulse; returns to IDLE on the next edge
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    // One extra scratch digit beyond the presented ones is kept so that
    // operands needing more than DIGITS decimal digits can be flagged.
    localparam int SW = (DIGITS + 1) * 4;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      r_bin;
    logic [SW-1:0]         r_scr;
    logic [CW-1:0]         r_cnt;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf;
    logic                  r_busy;
    logic                  r_done;

    logic [SW-1:0]         w_adj;
    logic [SW+WIDTH-1:0]   w_shift;
    logic                  w_last;

    // Add 3 to every digit >= 5 before the shift, so the doubling carries
    // correctly into the next decimal digit.
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj, r_bin} << 1;
        w_last  = (r_cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // busy/done are registered from the next state so they line up exactly
    // with SHIFT/DONE without a combinational output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_SHIFT);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin <= '0;
            r_scr <= '0;
            r_cnt <= '0;
            r_bcd <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin <= bus.bin;
                        r_scr <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_scr <= w_shift[SW+WIDTH-1:WIDTH];
                    r_bin <= w_shift[WIDTH-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bcd <= w_shift[WIDTH +: 4*DIGITS];
                        r_ovf <= |w_shift[WIDTH + 4*DIGITS +: 4];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
// Scoreboard bench for bin2bcd_seq: expected {ovf,bcd} values are queued when
// a start is accepted and compared when the converter pulses done. A small
// timing model tracks when busy/done must be high.
module tb_bin2bcd_seq;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 4;

    logic clk;
    logic rst;

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ovf, bcd} computed arithmetically from the operand.
    function automatic logic [16:0] exp_of(input int v);
        logic [15:0] b;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {(v >= 10000), b};
    endfunction

    logic [16:0] q[$];
    int          m_tm   = 0;     // edges left until back in IDLE; 0 = idle
    int          m_acc  = 0;
    logic [16:0] m_hold = '0;
    int          cyc    = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          prev_done_cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tm   = 0;
            m_hold = '0;
            q.delete();
        end else if (m_tm > 0) begin
            m_tm--;
        end else if (bus.start) begin
            q.push_back(exp_of(int'(bus.bin)));
            m_tm = WIDTH + 1;
            m_acc++;
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            chk("busy", 32'(bus.busy), 32'(m_tm >= 2));
            chk("done", 32'(bus.done), 32'(m_tm == 1));
            if (bus.done) begin
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                e = (q.size() > 0) ? q.pop_front() : 17'h1ffff;
                chk("result", 32'({bus.ovf, bus.bcd}), 32'(e));
                m_hold = e;
            end else begin
                chk("hold", 32'({bus.ovf, bus.bcd}), 32'(m_hold));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 60 && m_tm != 0; i++) @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [15:0] v);
        int dc0;
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        bus.bin   = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        chk("ndone", 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        int dc0;
        int a0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd",  32'(bus.bcd),  32'd0);
        chk("rst_ovf",  32'(bus.ovf),  32'd0);
        rst = 1'b0;

        convert(16'd0);
        convert(16'd42);
        convert(16'd9999);
        convert(16'd1905);
        convert(16'd10000);
        convert(16'd65535);

        // Starts during SHIFT must be ignored, as must bin changes.
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        bus.bin   = 16'd123;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.bin   = 16'd777;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        chk("ign_ndone", 32'(done_cnt - dc0), 32'd1);
        chk("ign_bcd",   32'(bus.bcd), 32'h0123);

        // Asynchronous reset part-way through a conversion.
        @(posedge clk);
        #1;
        bus.bin   = 16'd4321;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_bcd",  32'(bus.bcd),  32'd0);
        chk("arst_ovf",  32'(bus.ovf),  32'd0);
        #3;
        rst = 1'b0;
        dc0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("arst_nodone", 32'(done_cnt - dc0), 32'd0);
        convert(16'd4321);
        chk("after_rst_bcd", 32'(bus.bcd), 32'h4321);

        // start held high: back-to-back conversions, operand alternating.
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        bus.bin   = 16'd5;
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a0 = m_acc;
            for (int i = 0; i < 40 && m_acc == a0; i++) @(posedge clk);
            #1;
            bus.bin = (bus.bin == 16'd5) ? 16'd50 : 16'd5;
        end
        bus.start = 1'b0;
        wait_idle();
        chk("b2b_ndone",  32'(done_cnt - dc0), 32'd4);
        chk("b2b_period", 32'(last_done_cyc - prev_done_cyc), 32'd18);
        chk("b2b_bcd",    32'(bus.bcd), 32'h0050);

        repeat (3) @(posedge clk);
        #1;
        chk("q_left", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
